// File: rtl/rf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_port_arbiter
// Description : Shares one 32x32 register file between two clients.
//               Requests use a REQ/GNT handshake. Each accepted request is
//               issued to the register file for exactly one cycle. Reads
//               return data in per-client registers with a one-cycle valid.
//               A tie between the clients is broken round-robin.
// Ports       : clk, rst_n              - clock, async active-low reset
//               c{0,1}_req/we           - request and op (1 = write)
//               c{0,1}_r1/r2/w_addr     - operand addresses
//               c{0,1}_w_data           - write data
//               c{0,1}_gnt              - grant pulse (ISSUE cycle)
//               c{0,1}_rvalid           - read data valid pulse
//               c{0,1}_r1/r2_data       - captured read data
//               rf_read/rf_write        - one-hot register file controls
//               rf_r1/r2/w_addr, rf_w_data - register file operands
//               rf_r1/r2_data           - register file read data (comb)
// Revision    : 1.0 - initial release
// ============================================================================
module rf_port_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c0_req,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_r1_addr,
   input  logic [ADDR_WIDTH-1:0] c0_r2_addr,
   input  logic [ADDR_WIDTH-1:0] c0_w_addr,
   input  logic [DATA_WIDTH-1:0] c0_w_data,
   output logic                  c0_gnt,
   output logic                  c0_rvalid,
   output logic [DATA_WIDTH-1:0] c0_r1_data,
   output logic [DATA_WIDTH-1:0] c0_r2_data,
   input  logic                  c1_req,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_r1_addr,
   input  logic [ADDR_WIDTH-1:0] c1_r2_addr,
   input  logic [ADDR_WIDTH-1:0] c1_w_addr,
   input  logic [DATA_WIDTH-1:0] c1_w_data,
   output logic                  c1_gnt,
   output logic                  c1_rvalid,
   output logic [DATA_WIDTH-1:0] c1_r1_data,
   output logic [DATA_WIDTH-1:0] c1_r2_data,
   output logic                  rf_read,
   output logic                  rf_write,
   output logic [ADDR_WIDTH-1:0] rf_r1_addr,
   output logic [ADDR_WIDTH-1:0] rf_r2_addr,
   output logic [ADDR_WIDTH-1:0] rf_w_addr,
   output logic [DATA_WIDTH-1:0] rf_w_data,
   input  logic [DATA_WIDTH-1:0] rf_r1_data,
   input  logic [DATA_WIDTH-1:0] rf_r2_data
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   logic [0:0] state;
   logic [0:0] state_nxt;
   logic       win;       // client owning the current/last issue
   logic       win_nxt;
   logic       last;      // last client granted; loses the next tie
   logic       op_we;     // latched op of the winner
   logic       accept;

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         win   <= 1'b0;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         win   <= win_nxt;
         if (accept) begin
            last <= win_nxt;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and winner selection. Requests are looked at only in IDLE,
   // so a client that keeps REQ high through its ISSUE cycle is not
   // granted twice for the same operation.
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      win_nxt   = win;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (c0_req || c1_req) begin
               accept    = 1'b1;
               state_nxt = ISSUE;
               if (c0_req && c1_req) begin
                  win_nxt = ~last;
               end else begin
                  win_nxt = c1_req;
               end
            end
         end
         ISSUE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode from registered state
   // ---------------------------------------------------------------------
   always_comb begin
      c0_gnt   = (state == ISSUE) && !win;
      c1_gnt   = (state == ISSUE) &&  win;
      rf_write = (state == ISSUE) &&  op_we;
      rf_read  = (state == ISSUE) && !op_we;
   end

   // ---------------------------------------------------------------------
   // Operand latch and read-data capture
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_we      <= 1'b0;
         rf_r1_addr <= '0;
         rf_r2_addr <= '0;
         rf_w_addr  <= '0;
         rf_w_data  <= '0;
         c0_r1_data <= '0;
         c0_r2_data <= '0;
         c1_r1_data <= '0;
         c1_r2_data <= '0;
         c0_rvalid  <= 1'b0;
         c1_rvalid  <= 1'b0;
      end else begin
         c0_rvalid <= 1'b0;
         c1_rvalid <= 1'b0;
         if (accept) begin
            if (win_nxt) begin
               op_we      <= c1_we;
               rf_r1_addr <= c1_r1_addr;
               rf_r2_addr <= c1_r2_addr;
               rf_w_addr  <= c1_w_addr;
               rf_w_data  <= c1_w_data;
            end else begin
               op_we      <= c0_we;
               rf_r1_addr <= c0_r1_addr;
               rf_r2_addr <= c0_r2_addr;
               rf_w_addr  <= c0_w_addr;
               rf_w_data  <= c0_w_data;
            end
         end
         // Read data from the register file is combinational, so it is
         // valid at the edge that closes the read ISSUE cycle.
         if ((state == ISSUE) && !op_we) begin
            if (win) begin
               c1_r1_data <= rf_r1_data;
               c1_r2_data <= rf_r2_data;
               c1_rvalid  <= 1'b1;
            end else begin
               c0_r1_data <= rf_r1_data;
               c0_r2_data <= rf_r2_data;
               c0_rvalid  <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_port_arbiter
// Description : Self-checking bench for rf_port_arbiter with a behavioural
//               register file and per-client read-result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_port_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          c0_req, c0_we, c1_req, c1_we;
   logic [AW-1:0] c0_r1_addr, c0_r2_addr, c0_w_addr;
   logic [AW-1:0] c1_r1_addr, c1_r2_addr, c1_w_addr;
   logic [DW-1:0] c0_w_data, c1_w_data;
   logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
   logic [DW-1:0] c0_r1_data, c0_r2_data, c1_r1_data, c1_r2_data;
   logic          rf_read, rf_write;
   logic [AW-1:0] rf_r1_addr, rf_r2_addr, rf_w_addr;
   logic [DW-1:0] rf_w_data, rf_r1_data, rf_r2_data;

   typedef struct packed {
      logic [DW-1:0] r1;
      logic [DW-1:0] r2;
   } exp_t;

   exp_t          sb0[$];
   exp_t          sb1[$];
   exp_t          mon_e;
   logic [DW-1:0] rf_mem [32] = '{default: '0};
   logic [DW-1:0] shadow [32];
   int            tests = 0;
   int            failed = 0;
   int            cyc = 0;
   int            rand_stop = 0;
   logic          p_gnt0 = 1'b0, p_gnt1 = 1'b0, p_read = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   rf_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .c0_req(c0_req), .c0_we(c0_we), .c0_r1_addr(c0_r1_addr),
      .c0_r2_addr(c0_r2_addr), .c0_w_addr(c0_w_addr), .c0_w_data(c0_w_data),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid),
      .c0_r1_data(c0_r1_data), .c0_r2_data(c0_r2_data),
      .c1_req(c1_req), .c1_we(c1_we), .c1_r1_addr(c1_r1_addr),
      .c1_r2_addr(c1_r2_addr), .c1_w_addr(c1_w_addr), .c1_w_data(c1_w_data),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid),
      .c1_r1_data(c1_r1_data), .c1_r2_data(c1_r2_data),
      .rf_read(rf_read), .rf_write(rf_write),
      .rf_r1_addr(rf_r1_addr), .rf_r2_addr(rf_r2_addr),
      .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
      .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data)
   );

   // Behavioural register file: synchronous write, combinational read.
   always @(posedge clk) if (rf_write) rf_mem[rf_w_addr] <= rf_w_data;
   assign rf_r1_data = rf_mem[rf_r1_addr];
   assign rf_r2_data = rf_mem[rf_r2_addr];

   // Per-cycle invariants and scoreboard pop on every read return.
   always @(posedge clk) begin
      #1;
      if (rst_n === 1'b1) begin
         tests++;
         if (rf_read && rf_write) begin
            failed++; $display("FAIL rd_wr_onehot: got both high at cycle %0d, required one-hot", cyc);
         end
         tests++;
         if (c0_gnt && c1_gnt) begin
            failed++; $display("FAIL single_gnt: got two grants at cycle %0d, required at most one", cyc);
         end
         if (c0_rvalid) begin
            tests++;
            if (!(p_gnt0 && p_read)) begin
               failed++; $display("FAIL rvalid0_timing: rvalid without read grant in previous cycle (cycle %0d)", cyc);
            end
            tests++;
            if (sb0.size() == 0) begin
               failed++; $display("FAIL rvalid0_unexpected: got rvalid, required none (cycle %0d)", cyc);
            end else begin
               mon_e = sb0.pop_front();
               if ({c0_r1_data, c0_r2_data} !== {mon_e.r1, mon_e.r2}) begin
                  failed++; $display("FAIL c0_rdata: got %h_%h required %h_%h", c0_r1_data, c0_r2_data, mon_e.r1, mon_e.r2);
               end
            end
         end
         if (c1_rvalid) begin
            tests++;
            if (!(p_gnt1 && p_read)) begin
               failed++; $display("FAIL rvalid1_timing: rvalid without read grant in previous cycle (cycle %0d)", cyc);
            end
            tests++;
            if (sb1.size() == 0) begin
               failed++; $display("FAIL rvalid1_unexpected: got rvalid, required none (cycle %0d)", cyc);
            end else begin
               mon_e = sb1.pop_front();
               if ({c1_r1_data, c1_r2_data} !== {mon_e.r1, mon_e.r2}) begin
                  failed++; $display("FAIL c1_rdata: got %h_%h required %h_%h", c1_r1_data, c1_r2_data, mon_e.r1, mon_e.r2);
               end
            end
         end
         p_gnt0 = c0_gnt; p_gnt1 = c1_gnt; p_read = rf_read;
      end else begin
         p_gnt0 = 1'b0; p_gnt1 = 1'b0; p_read = 1'b0;
      end
   end

   task automatic idle_clients();
      c0_req = 0; c0_we = 0; c0_r1_addr = '0; c0_r2_addr = '0; c0_w_addr = '0; c0_w_data = '0;
      c1_req = 0; c1_we = 0; c1_r1_addr = '0; c1_r2_addr = '0; c1_w_addr = '0; c1_w_data = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_clients();
      @(posedge clk); #1;
      tests++;
      if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rf_read, rf_write} !== 6'b0) begin
         failed++; $display("FAIL reset_ctl: got %b required 000000", {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rf_read, rf_write});
      end
      tests++;
      if ({rf_r1_addr, rf_r2_addr, rf_w_addr, rf_w_data} !== '0) begin
         failed++; $display("FAIL reset_rf_regs: got nonzero %h, required 0", {rf_r1_addr, rf_r2_addr, rf_w_addr, rf_w_data});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      @(negedge clk);
      c0_we = 1; c0_w_addr = 5'd5; c0_w_data = 32'hDEADBEEF; c0_req = 1;
      @(posedge clk); #1;
      tests++;
      if ({c0_gnt, c1_gnt, rf_write, rf_read, rf_w_addr, rf_w_data} !== {4'b1010, 5'd5, 32'hDEADBEEF}) begin
         failed++; $display("FAIL wr_issue: got gnt=%b%b w=%b r=%b addr=%0d data=%h required 1010/5/deadbeef",
                            c0_gnt, c1_gnt, rf_write, rf_read, rf_w_addr, rf_w_data);
      end
      @(negedge clk);
      c0_we = 0; c0_r1_addr = 5'd5; c0_r2_addr = 5'd0;
      sb0.push_back('{r1: 32'hDEADBEEF, r2: 32'h0});
      @(posedge clk); #1;
      tests++;
      if (c0_gnt !== 1'b0) begin
         failed++; $display("FAIL no_double_gnt: got c0_gnt=%b required 0", c0_gnt);
      end
      @(posedge clk); #1;
      tests++;
      if ({c0_gnt, rf_read, rf_write, rf_r1_addr, rf_r2_addr} !== {3'b110, 5'd5, 5'd0}) begin
         failed++; $display("FAIL rd_issue: got gnt=%b r=%b w=%b a1=%0d a2=%0d required 1/1/0/5/0",
                            c0_gnt, rf_read, rf_write, rf_r1_addr, rf_r2_addr);
      end
      @(negedge clk);
      c0_req = 0;
      @(posedge clk); #1;
      tests++;
      if ({c0_rvalid, c0_r1_data, c0_r2_data} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
         failed++; $display("FAIL rd_return: got v=%b %h %h required 1 deadbeef 00000000", c0_rvalid, c0_r1_data, c0_r2_data);
      end
   endtask

   // Asynchronous reset asserted between clock edges, then released.
   task automatic test_reset_midrun();
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rf_read, rf_write} !== 6'b0) begin
         failed++; $display("FAIL midrun_ctl: got %b required 000000", {c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, rf_read, rf_write});
      end
      tests++;
      if ({c0_r1_data, c0_r2_data, c1_r1_data, c1_r2_data, rf_w_addr, rf_r1_addr, rf_w_data} !== '0) begin
         failed++; $display("FAIL midrun_data: got c0_r1=%h rf_w_data=%h required 0", c0_r1_data, rf_w_data);
      end
      idle_clients();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_tie_after_reset();
      logic e0, e1;
      c0_we = 1; c0_w_addr = 5'd1; c0_w_data = 32'h11111111;
      c1_we = 1; c1_w_addr = 5'd2; c1_w_data = 32'h22222222;
      c0_req = 1; c1_req = 1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         e0 = (k == 1) || (k == 5);
         e1 = (k == 3) || (k == 7);
         tests++;
         if ({c0_gnt, c1_gnt} !== {e0, e1}) begin
            failed++; $display("FAIL tie_cycle%0d: got gnt=%b%b required %b%b", k, c0_gnt, c1_gnt, e0, e1);
         end
      end
      c0_req = 0; c1_req = 0;
      @(negedge clk);
   endtask

   task automatic test_priority();
      c0_we = 1; c0_w_addr = 5'd9; c0_w_data = 32'h0BADF00D; c0_req = 1;
      @(posedge clk); #1;
      tests++;
      if (c0_gnt !== 1'b1) begin
         failed++; $display("FAIL prio_setup: got c0_gnt=%b required 1", c0_gnt);
      end
      @(negedge clk);
      c0_we = 0; c0_r1_addr = 5'd7; c0_r2_addr = 5'd7;
      c1_we = 1; c1_w_addr = 5'd7; c1_w_data = 32'h12345678; c1_req = 1;
      sb0.push_back('{r1: 32'h12345678, r2: 32'h12345678});
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if ({c0_gnt, c1_gnt, rf_write} !== 3'b011) begin
         failed++; $display("FAIL prio_c1_first: got gnt=%b%b w=%b required 01/1", c0_gnt, c1_gnt, rf_write);
      end
      @(negedge clk);
      c1_req = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if ({c0_gnt, rf_read} !== 2'b11) begin
         failed++; $display("FAIL prio_c0_second: got gnt=%b r=%b required 1/1", c0_gnt, rf_read);
      end
      @(negedge clk);
      c0_req = 0;
      @(posedge clk); #1;
      tests++;
      if ({c0_rvalid, c0_r1_data} !== {1'b1, 32'h12345678}) begin
         failed++; $display("FAIL prio_data: got v=%b %h required 1 12345678", c0_rvalid, c0_r1_data);
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      c0_we = 1; c0_w_addr = 5'd3; c0_w_data = 32'hA5A5A5A5; c0_req = 1;
      @(posedge clk); #1;
      tests++;
      if (rf_write !== 1'b1) begin
         failed++; $display("FAIL midop_issue: got rf_write=%b required 1", rf_write);
      end
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({rf_write, c0_gnt} !== 2'b00) begin
         failed++; $display("FAIL midop_drop: got w=%b gnt=%b required 00", rf_write, c0_gnt);
      end
      c0_req = 0;
      @(posedge clk); #1;
      tests++;
      if (rf_mem[3] === 32'hA5A5A5A5) begin
         failed++; $display("FAIL midop_nowrite: got rf[3]=%h required not a5a5a5a5", rf_mem[3]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      c0_req = 1;
      @(posedge clk); #1;
      tests++;
      if ({c0_gnt, rf_write, rf_w_addr} !== {2'b11, 5'd3}) begin
         failed++; $display("FAIL midop_retry: got gnt=%b w=%b addr=%0d required 1/1/3", c0_gnt, rf_write, rf_w_addr);
      end
      @(negedge clk);
      c0_we = 0; c0_r1_addr = 5'd3; c0_r2_addr = 5'd5;
      sb0.push_back('{r1: 32'hA5A5A5A5, r2: 32'hDEADBEEF});
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (c0_gnt !== 1'b1) begin
         failed++; $display("FAIL midop_readback_gnt: got %b required 1", c0_gnt);
      end
      @(negedge clk);
      c0_req = 0;
      repeat (2) @(negedge clk);
   endtask

   // One client's traffic; each client stays in its own half of the
   // register file so expectations can be formed when the request is made.
   task automatic client_loop(input int c);
      int            waited;
      logic          got;
      logic          we;
      logic [AW-1:0] a1, a2, wa;
      logic [DW-1:0] wd;
      while (cyc < rand_stop) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         we = 1'($urandom_range(0, 1));
         a1 = AW'(c * 16 + $urandom_range(0, 15));
         a2 = AW'(c * 16 + $urandom_range(0, 15));
         wa = AW'(c * 16 + $urandom_range(0, 15));
         wd = $urandom;
         if (we) shadow[wa] = wd;
         else if (c == 0) sb0.push_back('{r1: shadow[a1], r2: shadow[a2]});
         else sb1.push_back('{r1: shadow[a1], r2: shadow[a2]});
         if (c == 0) begin
            c0_we = we; c0_r1_addr = a1; c0_r2_addr = a2; c0_w_addr = wa; c0_w_data = wd; c0_req = 1;
         end else begin
            c1_we = we; c1_r1_addr = a1; c1_r2_addr = a2; c1_w_addr = wa; c1_w_data = wd; c1_req = 1;
         end
         waited = 0;
         got = 1'b0;
         while (!got && waited < 8) begin
            @(posedge clk); #1;
            waited++;
            got = (c == 0) ? c0_gnt : c1_gnt;
         end
         tests++;
         if (!got || waited > 4) begin
            failed++; $display("FAIL rand_wait_c%0d: got gnt=%b after %0d cycles, required within 4", c, got, waited);
         end
         @(negedge clk);
         if (c == 0) c0_req = 0;
         else c1_req = 0;
      end
   endtask

   task automatic test_random();
      int bad;
      for (int i = 0; i < 32; i++) shadow[i] = rf_mem[i];
      @(negedge clk);
      rand_stop = cyc + 10000;
      fork
         client_loop(0);
         client_loop(1);
      join
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (sb0.size() != 0 || sb1.size() != 0) begin
         failed++; $display("FAIL rand_drain: got %0d/%0d pending reads, required 0/0", sb0.size(), sb1.size());
      end
      bad = 0;
      for (int i = 0; i < 32; i++) if (rf_mem[i] !== shadow[i]) bad++;
      tests++;
      if (bad != 0) begin
         failed++; $display("FAIL rand_rf_contents: got %0d differing registers, required 0", bad);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_read();
      test_reset_midrun();
      test_tie_after_reset();
      test_priority();
      test_reset_mid_op();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
